// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction per request, store lane
// steering, load byte/halfword extraction and sign/zero extension.
module lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic [4:0]            resp_rd_o,
  output logic                  resp_is_load_o,
  output logic                  resp_fault_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        is_store_q;

  logic        req_fault;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_lanes;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Illegal funct3 or misalignment is decided in IDLE so a faulting request
  // never reaches the memory bus.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    req_fault = 1'b0;
    if (req_is_store_i) begin
      req_fault = req_funct3_i[2] | (&req_funct3_i[1:0]);
    end else begin
      req_fault = (req_funct3_i == 3'b011) | (&req_funct3_i[2:1]);
    end
    case (req_funct3_i[1:0])
      2'b01:   if (req_addr_i[0])           req_fault = 1'b1;
      2'b10:   if (req_addr_i[1:0] != 2'b00) req_fault = 1'b1;
      default: ;
    endcase
  end

  // Store lane steering; loads always read the whole word.
  always_comb begin
    req_be          = 4'b1111;
    req_wdata_lanes = req_wdata_i;
    if (req_is_store_i) begin
      case (req_funct3_i[1:0])
        2'b00: begin
          req_be          = 4'b0001 << req_addr_i[1:0];
          req_wdata_lanes = {4{req_wdata_i[7:0]}};
        end
        2'b01: begin
          req_be          = req_addr_i[1] ? 4'b1100 : 4'b0011;
          req_wdata_lanes = {2{req_wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction uses the byte offset latched at accept time.
  always_comb begin
    load_byte = mem_rdata_i[{off_q, 3'b000} +: 8];
    load_half = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_BU:   load_data = {24'd0, load_byte};
      F3_HU:   load_data = {16'd0, load_half};
      default: load_data = mem_rdata_i;
    endcase
  end

  // All outputs are registered; the asynchronous reset clears mem_valid_o
  // the moment rst_ni falls, abandoning any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      funct3_q       <= 3'd0;
      off_q          <= 2'd0;
      rd_q           <= 5'd0;
      is_store_q     <= 1'b0;
      req_ready_o    <= 1'b1;
      mem_valid_o    <= 1'b0;
      mem_addr_o     <= '0;
      mem_we_o       <= 1'b0;
      mem_be_o       <= 4'd0;
      mem_wdata_o    <= 32'd0;
      resp_valid_o   <= 1'b0;
      resp_rdata_o   <= 32'd0;
      resp_rd_o      <= 5'd0;
      resp_is_load_o <= 1'b0;
      resp_fault_o   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            funct3_q    <= req_funct3_i;
            off_q       <= req_addr_i[1:0];
            rd_q        <= req_rd_i;
            is_store_q  <= req_is_store_i;
            req_ready_o <= 1'b0;
            if (req_fault) begin
              state          <= RESP;
              resp_valid_o   <= 1'b1;
              resp_fault_o   <= 1'b1;
              resp_rdata_o   <= 32'd0;
              resp_rd_o      <= req_rd_i;
              resp_is_load_o <= ~req_is_store_i;
            end else begin
              state       <= REQ;
              mem_valid_o <= 1'b1;
              mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
              mem_we_o    <= req_is_store_i;
              mem_be_o    <= req_be;
              mem_wdata_o <= req_is_store_i ? req_wdata_lanes : 32'd0;
            end
          end
        end

        REQ: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
            if (is_store_q) begin
              state          <= RESP;
              resp_valid_o   <= 1'b1;
              resp_rdata_o   <= 32'd0;
              resp_rd_o      <= rd_q;
              resp_is_load_o <= 1'b0;
              resp_fault_o   <= 1'b0;
            end else begin
              state <= WAIT_R;
            end
          end
        end

        WAIT_R: begin
          if (mem_rvalid_i) begin
            state          <= RESP;
            resp_valid_o   <= 1'b1;
            resp_rdata_o   <= load_data;
            resp_rd_o      <= rd_q;
            resp_is_load_o <= 1'b1;
            resp_fault_o   <= 1'b0;
          end
        end

        RESP: begin
          state          <= IDLE;
          req_ready_o    <= 1'b1;
          resp_valid_o   <= 1'b0;
          resp_rdata_o   <= 32'd0;
          resp_rd_o      <= 5'd0;
          resp_is_load_o <= 1'b0;
          resp_fault_o   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: stores, loads, faults, wait states
// and reset mid-transaction.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_is_store_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_o;
  logic        resp_is_load_o;
  logic        resp_fault_o;

  int passed = 0;
  int total  = 0;

  lsu #(.ADDR_WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_is_store_i (req_is_store_i),
    .req_funct3_i   (req_funct3_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_rd_i       (req_rd_i),
    .mem_valid_o    (mem_valid_o),
    .mem_ready_i    (mem_ready_i),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_rd_o      (resp_rd_o),
    .resp_is_load_o (resp_is_load_o),
    .resp_fault_o   (resp_fault_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and return at the following falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Present a request for one cycle; returns at cycle 1 (after accept).
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd);
    req_valid_i    = 1'b1;
    req_is_store_i = st;
    req_funct3_i   = f3;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_rd_i       = rd;
    step();
    req_valid_i    = 1'b0;
  endtask

  // Load with ready at once and rvalid one cycle after accept.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    mem_ready_i = 1'b1;
    send(1'b0, f3, addr, 32'd0, 5'd7);
    check({tag, " mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    check({tag, " mem_we"}, mem_we_o, 1'b0);
    check({tag, " mem_be"}, mem_be_o, 4'b1111);
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    step();
    mem_rvalid_i = 1'b0;
    check({tag, " resp_valid"}, resp_valid_o, 1'b1);
    check({tag, " rdata"}, resp_rdata_o, exp);
    check({tag, " rd"}, resp_rd_o, 5'd7);
    check({tag, " is_load"}, resp_is_load_o, 1'b1);
    step();
    check({tag, " resp_drop"}, resp_valid_o, 1'b0);
  endtask

  // Faulting request: response at cycle 1, bus never used.
  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr);
    mem_ready_i = 1'b1;
    send(st, f3, addr, 32'hFFFF_FFFF, 5'd3);
    check({tag, " resp_valid"}, resp_valid_o, 1'b1);
    check({tag, " fault"}, resp_fault_o, 1'b1);
    check({tag, " rdata"}, resp_rdata_o, 32'd0);
    check({tag, " mem_valid"}, mem_valid_o, 1'b0);
    step();
    check({tag, " mem_valid_after"}, mem_valid_o, 1'b0);
    check({tag, " ready_back"}, req_ready_o, 1'b1);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_is_store_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0; req_rd_i = 5'd0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    repeat (2) @(negedge clk_i);
    check("rst ready", req_ready_o, 1'b1);
    check("rst mem_valid", mem_valid_o, 1'b0);
    check("rst resp_valid", resp_valid_o, 1'b0);
    check("rst resp_rdata", resp_rdata_o, 32'd0);
    rst_ni = 1'b1;
    step();

    // SW 0x100
    mem_ready_i = 1'b1;
    send(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd1);
    check("sw mem_valid", mem_valid_o, 1'b1);
    check("sw addr", mem_addr_o, 32'h100);
    check("sw be", mem_be_o, 4'b1111);
    check("sw we", mem_we_o, 1'b1);
    check("sw wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check("sw ready_low", req_ready_o, 1'b0);
    step();
    check("sw resp_valid", resp_valid_o, 1'b1);
    check("sw is_load", resp_is_load_o, 1'b0);
    check("sw fault", resp_fault_o, 1'b0);
    check("sw resp_ready", req_ready_o, 1'b0);
    step();
    check("sw resp_drop", resp_valid_o, 1'b0);
    check("sw ready_back", req_ready_o, 1'b1);

    // SB 0x103, SH 0x102
    send(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd0);
    check("sb addr", mem_addr_o, 32'h100);
    check("sb be", mem_be_o, 4'b1000);
    check("sb wdata", mem_wdata_o, 32'hA5A5_A5A5);
    step(); step();
    send(1'b1, 3'b001, 32'h102, 32'h0000_1234, 5'd0);
    check("sh be", mem_be_o, 4'b1100);
    check("sh wdata", mem_wdata_o, 32'h1234_1234);
    step(); step();

    // Loads from 0x80F17F02
    do_load("lb103",  3'b000, 32'h103, 32'h80F1_7F02, 32'hFFFF_FF80);
    do_load("lbu103", 3'b100, 32'h103, 32'h80F1_7F02, 32'h0000_0080);
    do_load("lb101",  3'b000, 32'h101, 32'h80F1_7F02, 32'h0000_007F);
    do_load("lh102",  3'b001, 32'h102, 32'h80F1_7F02, 32'hFFFF_80F1);
    do_load("lhu100", 3'b101, 32'h100, 32'h80F1_7F02, 32'h0000_7F02);
    do_load("lw100",  3'b010, 32'h100, 32'h80F1_7F02, 32'h80F1_7F02);

    // Faults
    do_fault("lw101",  1'b0, 3'b010, 32'h101);
    do_fault("lh103",  1'b0, 3'b001, 32'h103);
    do_fault("st011",  1'b1, 3'b011, 32'h100);
    do_fault("ld110",  1'b0, 3'b110, 32'h100);

    // Wait states: ready low 4 cycles, rvalid 2 cycles after accept
    mem_ready_i = 1'b0;
    send(1'b0, 3'b010, 32'h204, 32'd0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      check("ws mem_valid", mem_valid_o, 1'b1);
      check("ws addr", mem_addr_o, 32'h204);
      check("ws be", mem_be_o, 4'b1111);
      check("ws ready_low", req_ready_o, 1'b0);
      step();
    end
    check("ws still_valid", mem_valid_o, 1'b1);
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    check("ws accepted", mem_valid_o, 1'b0);
    step();
    check("ws no_early_resp", resp_valid_o, 1'b0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1122_3344;
    step();
    mem_rvalid_i = 1'b0;
    check("ws resp_valid", resp_valid_o, 1'b1);
    check("ws rdata", resp_rdata_o, 32'h1122_3344);
    check("ws rd", resp_rd_o, 5'd9);
    step();
    check("ws single_pulse", resp_valid_o, 1'b0);

    // Reset while in REQ: mem_valid_o must drop before any clock edge
    send(1'b0, 3'b010, 32'h300, 32'd0, 5'd4);
    check("rstreq mem_valid_pre", mem_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("rstreq mem_valid", mem_valid_o, 1'b0);
    check("rstreq ready", req_ready_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Reset while in WAIT_R, then a stray rvalid
    mem_ready_i = 1'b1;
    send(1'b0, 3'b010, 32'h300, 32'd0, 5'd4);
    step();
    mem_ready_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("rstwr mem_valid", mem_valid_o, 1'b0);
    check("rstwr resp_valid", resp_valid_o, 1'b0);
    check("rstwr ready", req_ready_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    step();
    mem_rvalid_i = 1'b0;
    check("stray resp_valid", resp_valid_o, 1'b0);
    step();
    check("stray resp_valid2", resp_valid_o, 1'b0);
    check("stray ready", req_ready_o, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
